// File: rtl/morra_pkg.sv
// Shared types and move-ordering helper for the morra cinese referee.
// Pure declarations: no latency, no flow control.
// Optional no-repeat rule is selected with MORRA_NO_REPEAT_EN.
package morra_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        SASSO   = 2'b01,
        CARTA   = 2'b10,
        FORBICE = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        NESSUNO  = 2'b00,
        VINCE_P1 = 2'b01,
        VINCE_P2 = 2'b10,
        PARI     = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic beats(input move_t a, input move_t b);
        return (a == SASSO   && b == FORBICE) ||
               (a == FORBICE && b == CARTA)   ||
               (a == CARTA   && b == SASSO);
    endfunction

endpackage

// File: rtl/morra_arbitro.sv
// Single-manche judge: validity and winner of one pair of moves.
// Purely combinational, no flow control.
// With MORRA_NO_REPEAT_EN a repeat of a player's own last valid move is invalid.
module morra_arbitro
    import morra_pkg::*;
(
    input  move_t   p1_i,
    input  move_t   p2_i,
`ifdef MORRA_NO_REPEAT_EN
    input  move_t   last1_i,
    input  move_t   last2_i,
`endif
    output logic    valid_o,
    output result_t res_o
);

    logic repeat_hit;

`ifdef MORRA_NO_REPEAT_EN
    // last moves are NONE right after a start, so they never match a legal move
    assign repeat_hit = (p1_i == last1_i) || (p2_i == last2_i);
`else
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        valid_o = (p1_i != NONE) && (p2_i != NONE) && !repeat_hit;
        res_o   = NESSUNO;
        if (valid_o) begin
            if (p1_i == p2_i)           res_o = PARI;
            else if (beats(p1_i, p2_i)) res_o = VINCE_P1;
            else                        res_o = VINCE_P2;
        end
    end

endmodule

// File: rtl/morra_cinese_param.sv
// Rock-paper-scissors match referee: scores manches, ends on limit or early lead.
// Results registered one CLK after the moves are sampled; no backpressure.
// MORRA_NO_REPEAT_EN enables the no-repeat rule (last-move registers).
module morra_cinese_param
    import morra_pkg::*;
#(
    parameter int MIN_MANCHE  = 4,
    parameter int PROG_W      = 4,
    parameter int LEAD_MARGIN = 2,
    localparam int MAX_LIM    = MIN_MANCHE + 2**PROG_W - 1,
    localparam int CNT_W      = $clog2(MAX_LIM + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    input  logic             INIZIA,
    output logic [1:0]       MANCHE,
    output logic [1:0]       PARTITA,
    output logic [CNT_W-1:0] N_MANCHE,
    output logic             FINE
);

    state_t           state_q;
    result_t          manche_q, partita_q;
    logic [CNT_W-1:0] n_q, s1_q, s2_q, lim_q;
    logic             fine_q;

    move_t   p1, p2;
    logic    valid;
    result_t res;

    assign p1 = move_t'(PRIMO);
    assign p2 = move_t'(SECONDO);

`ifdef MORRA_NO_REPEAT_EN
    move_t last1_q, last2_q;

    morra_arbitro u_arbitro (
        .p1_i    (p1),
        .p2_i    (p2),
        .last1_i (last1_q),
        .last2_i (last2_q),
        .valid_o (valid),
        .res_o   (res)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last1_q <= NONE;
            last2_q <= NONE;
        end else if (INIZIA) begin
            last1_q <= NONE;
            last2_q <= NONE;
        end else if (state_q == PLAY && valid) begin
            last1_q <= p1;
            last2_q <= p2;
        end
    end
`else
    morra_arbitro u_arbitro (
        .p1_i    (p1),
        .p2_i    (p2),
        .valid_o (valid),
        .res_o   (res)
    );
`endif

    // Post-manche values, used both for the update and for the end check.
    logic [CNT_W-1:0] s1_d, s2_d, n_d, lead_d;
    result_t          leader_d;
    logic             end_d;

    always_comb begin
        s1_d     = s1_q + CNT_W'(res == VINCE_P1);
        s2_d     = s2_q + CNT_W'(res == VINCE_P2);
        n_d      = n_q + CNT_W'(1);
        lead_d   = (s1_d >= s2_d) ? (s1_d - s2_d) : (s2_d - s1_d);
        leader_d = (s1_d > s2_d) ? VINCE_P1 :
                   (s2_d > s1_d) ? VINCE_P2 : PARI;
        end_d    = ((n_d >= CNT_W'(MIN_MANCHE)) && (lead_d > CNT_W'(LEAD_MARGIN))) ||
                   (n_d == lim_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            manche_q  <= NESSUNO;
            partita_q <= NESSUNO;
            n_q       <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            lim_q     <= '0;
            fine_q    <= 1'b0;
        end else if (INIZIA) begin
            state_q   <= PLAY;
            manche_q  <= NESSUNO;
            partita_q <= NESSUNO;
            n_q       <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            lim_q     <= CNT_W'(MIN_MANCHE) + CNT_W'({PRIMO, SECONDO});
            fine_q    <= 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (valid) begin
                        manche_q <= res;
                        s1_q     <= s1_d;
                        s2_q     <= s2_d;
                        n_q      <= n_d;
                        if (end_d) begin
                            partita_q <= leader_d;
                            fine_q    <= 1'b1;
                            state_q   <= DONE;
                        end
                    end else begin
                        manche_q <= NESSUNO;
                    end
                end
                IDLE, DONE: manche_q <= NESSUNO;
                default: begin
                    state_q  <= IDLE;
                    manche_q <= NESSUNO;
                end
            endcase
        end
    end

    assign MANCHE   = manche_q;
    assign PARTITA  = partita_q;
    assign N_MANCHE = n_q;
    assign FINE     = fine_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Directed bench for the morra cinese referee; expectations hand-computed.
module tb_morra_cinese_param;

    localparam int CNT_W = 5;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [1:0]       PRIMO, SECONDO;
    logic             INIZIA;
    logic [1:0]       MANCHE, PARTITA;
    logic [CNT_W-1:0] N_MANCHE;
    logic             FINE;

    int n_chk  = 0;
    int n_pass = 0;

    morra_cinese_param dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PRIMO    (PRIMO),
        .SECONDO  (SECONDO),
        .INIZIA   (INIZIA),
        .MANCHE   (MANCHE),
        .PARTITA  (PARTITA),
        .N_MANCHE (N_MANCHE),
        .FINE     (FINE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input int m, input int p, input int n, input int f);
        check({tag, ".manche"},   int'(MANCHE),   m);
        check({tag, ".partita"},  int'(PARTITA),  p);
        check({tag, ".n_manche"}, int'(N_MANCHE), n);
        check({tag, ".fine"},     int'(FINE),     f);
    endtask

    task automatic play(input logic [1:0] a, input logic [1:0] b);
        PRIMO   = a;
        SECONDO = b;
        INIZIA  = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [3:0] prog);
        {PRIMO, SECONDO} = prog;
        INIZIA = 1'b1;
        @(posedge CLK);
        #1;
        INIZIA  = 1'b0;
        PRIMO   = 2'b00;
        SECONDO = 2'b00;
    endtask

    initial begin
        RST_N = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00; INIZIA = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset", 0, 0, 0, 0);
        RST_N = 1'b1;

        // moves in IDLE are ignored
        play(2'b01, 2'b11);
        check_all("idle_ignore", 0, 0, 0, 0);

        // tie to limit 4
        start(4'b0000);
        check_all("start0", 0, 0, 0, 0);
        play(2'b01, 2'b01); check_all("tie1", 3, 0, 1, 0);
        play(2'b10, 2'b10); check_all("tie2", 3, 0, 2, 0);
        play(2'b11, 2'b11); check_all("tie3", 3, 0, 3, 0);
        play(2'b01, 2'b01); check_all("tie4", 3, 3, 4, 1);
        play(2'b01, 2'b11); check_all("done_hold", 0, 3, 4, 1);

        // early lead, limit 7: 3-0 at manche 3 is not yet checked
        start(4'b0011);
        play(2'b01, 2'b11); check_all("lead1", 1, 0, 1, 0);
        play(2'b10, 2'b01); check_all("lead2", 1, 0, 2, 0);
        play(2'b11, 2'b10); check_all("lead3", 1, 0, 3, 0);
        play(2'b01, 2'b11); check_all("lead4", 1, 1, 4, 1);

        // restart from DONE, then leader at limit with an invalid cycle
        start(4'b0000);
        check_all("restart_done", 0, 0, 0, 0);
        play(2'b01, 2'b11); check_all("lim1", 1, 0, 1, 0);
        play(2'b00, 2'b10); check_all("lim_inv", 0, 0, 1, 0);
        play(2'b11, 2'b01); check_all("lim2", 2, 0, 2, 0);
        play(2'b01, 2'b11); check_all("lim3", 1, 0, 3, 0);
        play(2'b10, 2'b10); check_all("lim4", 3, 1, 4, 1);

        // repeat rule
        start(4'b0000);
        play(2'b01, 2'b11); check_all("rep1", 1, 0, 1, 0);
`ifdef MORRA_NO_REPEAT_EN
        play(2'b01, 2'b10); check_all("rep_p1", 0, 0, 1, 0);
        play(2'b10, 2'b10); check_all("rep_ok", 3, 0, 2, 0);
        play(2'b11, 2'b10); check_all("rep_p2", 0, 0, 2, 0);
`else
        play(2'b01, 2'b10); check_all("rep_p1", 2, 0, 2, 0);
        play(2'b10, 2'b10); check_all("rep_ok", 3, 0, 3, 0);
        play(2'b00, 2'b10); check_all("rep_inv", 0, 0, 3, 0);
`endif

        // INIZIA in PLAY with a valid move present: restart, move not scored
        start(4'b0111);
        check_all("restart_play", 0, 0, 0, 0);
        play(2'b01, 2'b11); check_all("after_restart", 1, 0, 1, 0);

        // mid-match asynchronous reset
        start(4'b0000);
        play(2'b01, 2'b11);
        play(2'b10, 2'b01); check_all("pre_rst", 1, 0, 2, 0);
        #2 RST_N = 1'b0;
        #1 check_all("async_rst", 0, 0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        play(2'b01, 2'b11); check_all("rst_idle", 0, 0, 0, 0);
        start(4'b0000);
        play(2'b11, 2'b10); check_all("rst_resume", 1, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
